// File: rtl/fwd_pkg.sv
// Shared types for the forwarding scoreboard: the per-stage entry record and
// the readiness rule deciding whether an in-flight result can be forwarded yet.
package fwd_pkg;

    // Register indices are stored zero-extended, so REG_INDEX_BIT_WIDTH must not exceed this.
    localparam int IND_MAX_W = 8;

    typedef struct packed {
        logic                 valid;
        logic [IND_MAX_W-1:0] wrtInd;
        logic                 isLoad;
    } fwdEntry_t;

    localparam int ENTRY_W = $bits(fwdEntry_t);

    function automatic logic entryReady(input fwdEntry_t e, input int stage, input int loadReadyStage);
        return !e.isLoad || (stage >= loadReadyStage);
    endfunction

endpackage

// File: rtl/fwd_match_select.sv
// Finds the youngest in-flight producer of one source operand and reports
// its stage index, whether any producer exists, and whether it is not yet ready.
module fwd_match_select
    import fwd_pkg::*;
#(
    parameter int STAGES              = 2,
    parameter int REG_INDEX_BIT_WIDTH = 4,
    parameter int LOAD_READY_STAGE    = 1
) (
    input  fwdEntry_t [STAGES-1:0]          entries,
    input  logic [REG_INDEX_BIT_WIDTH-1:0]  srcInd,
    input  logic                            srcUse,
    output logic [$clog2(STAGES)-1:0]       sel,
    output logic                            hit,
    output logic                            notReady
);

    localparam int SEL_W = $clog2(STAGES);

    logic [STAGES-1:0] matchVec;
    logic [STAGES-1:0] readyVec;

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_match
        assign matchVec[gi] = entries[gi].valid && srcUse &&
                              (entries[gi].wrtInd == IND_MAX_W'(srcInd));
        assign readyVec[gi] = entryReady(entries[gi], gi, LOAD_READY_STAGE);
    end

    // Scan oldest to youngest so the lowest matching stage overrides the rest.
    always_comb begin
        sel      = '0;
        hit      = 1'b0;
        notReady = 1'b0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            if (matchVec[k]) begin
                sel      = SEL_W'(k);
                hit      = 1'b1;
                notReady = !readyVec[k];
            end
        end
    end

endmodule

// File: rtl/fwd_scoreboard.sv
// Hazard/forwarding unit: shift-register scoreboard of in-flight destinations,
// youngest-producer operand forwarding and load-use stall. Optional counters: FWD_SCOREBOARD_STATS_EN.
module fwd_scoreboard
    import fwd_pkg::*;
#(
    parameter int DBITS               = 32,
    parameter int REG_INDEX_BIT_WIDTH = 4,
    parameter int STAGES              = 2,
    parameter int LOAD_READY_STAGE    = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           dec_valid,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] dec_src1_ind,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] dec_src2_ind,
    input  logic                           dec_src1_use,
    input  logic                           dec_src2_use,
    input  logic                           dec_wrt_en,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] dec_wrt_ind,
    input  logic                           dec_is_load,
    input  logic                           flush,
    input  logic [DBITS-1:0]               rf_src1_data,
    input  logic [DBITS-1:0]               rf_src2_data,
    input  logic [STAGES*DBITS-1:0]        stage_data,
    output logic [DBITS-1:0]               fwd_src1_data,
    output logic [DBITS-1:0]               fwd_src2_data,
    output logic                           stall,
    output logic                           issue
`ifdef FWD_SCOREBOARD_STATS_EN
    ,
    output logic [31:0]                    stall_count,
    output logic [31:0]                    fwd_count
`endif
);

    localparam int SEL_W = $clog2(STAGES);

    fwdEntry_t [STAGES-1:0] entryReg;
    fwdEntry_t              entryNext;
    logic [DBITS-1:0]       stageArr [STAGES];

    logic [SEL_W-1:0] sel1, sel2;
    logic             hit1, hit2;
    logic             notReady1, notReady2;
    logic             hazard;

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_slice
        assign stageArr[gi] = stage_data[gi*DBITS +: DBITS];
    end

    fwd_match_select #(
        .STAGES             (STAGES),
        .REG_INDEX_BIT_WIDTH(REG_INDEX_BIT_WIDTH),
        .LOAD_READY_STAGE   (LOAD_READY_STAGE)
    ) uSel1 (
        .entries (entryReg),
        .srcInd  (dec_src1_ind),
        .srcUse  (dec_src1_use),
        .sel     (sel1),
        .hit     (hit1),
        .notReady(notReady1)
    );

    fwd_match_select #(
        .STAGES             (STAGES),
        .REG_INDEX_BIT_WIDTH(REG_INDEX_BIT_WIDTH),
        .LOAD_READY_STAGE   (LOAD_READY_STAGE)
    ) uSel2 (
        .entries (entryReg),
        .srcInd  (dec_src2_ind),
        .srcUse  (dec_src2_use),
        .sel     (sel2),
        .hit     (hit2),
        .notReady(notReady2)
    );

    // Outputs are forced low while reset is asserted, even between clock edges.
    assign hazard = (hit1 && notReady1) || (hit2 && notReady2);
    assign stall  = reset && dec_valid && !flush && hazard;
    assign issue  = reset && dec_valid && !flush && !hazard;

    always_comb begin
        fwd_src1_data = rf_src1_data;
        fwd_src2_data = rf_src2_data;
        if (hit1 && !notReady1) begin
            fwd_src1_data = stageArr[sel1];
        end
        if (hit2 && !notReady2) begin
            fwd_src2_data = stageArr[sel2];
        end
    end

    always_comb begin
        entryNext = fwdEntry_t'(ENTRY_W'(0));
        if (issue && dec_wrt_en) begin
            entryNext.valid  = 1'b1;
            entryNext.wrtInd = IND_MAX_W'(dec_wrt_ind);
            entryNext.isLoad = dec_is_load;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            entryReg[0] <= fwdEntry_t'(ENTRY_W'(0));
        end else begin
            entryReg[0] <= entryNext;
        end
    end

    // Older stages keep advancing even while stage 0 takes a bubble.
    for (genvar gi = 1; gi < STAGES; gi++) begin : g_shift
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                entryReg[gi] <= fwdEntry_t'(ENTRY_W'(0));
            end else begin
                entryReg[gi] <= entryReg[gi-1];
            end
        end
    end

`ifdef FWD_SCOREBOARD_STATS_EN
    logic [31:0] stallCountReg;
    logic [31:0] fwdCountReg;
    logic        fwdEvent;

    assign fwdEvent = issue && (hit1 || hit2);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stallCountReg <= '0;
            fwdCountReg   <= '0;
        end else begin
            if (stall && (stallCountReg != '1)) begin
                stallCountReg <= stallCountReg + 32'd1;
            end
            if (fwdEvent && (fwdCountReg != '1)) begin
                fwdCountReg <= fwdCountReg + 32'd1;
            end
        end
    end

    assign stall_count = stallCountReg;
    assign fwd_count   = fwdCountReg;
`endif

endmodule
